// File: rtl/mux_pkg.sv
// Shared constants for the scanning N:1 multiplexer.
package mux_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [ST_W-1:0] ST_MANUAL = 2'd1;
  localparam logic [ST_W-1:0] ST_SCAN   = 2'd2;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Counter width able to hold 0..n-1, at least one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_counter.sv
// Scan position: channel counter advanced once every DWELL run cycles.
module scan_counter
  import mux_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned DWELL  = 4,
  localparam int unsigned CH_W   = cnt_w(NUM_CH),
  localparam int unsigned DW_W   = cnt_w(DWELL)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            clear,
  output logic [CH_W-1:0] ch
);

  logic [CH_W-1:0] ch_q, ch_d;
  logic [DW_W-1:0] dwell_q, dwell_d;

  // Next position: clear wins, otherwise step only while running, else freeze.
  always_comb begin
    ch_d    = ch_q;
    dwell_d = dwell_q;
    if (clear) begin
      ch_d    = '0;
      dwell_d = '0;
    end else if (run) begin
      if (dwell_q == DW_W'(DWELL - 1)) begin
        dwell_d = '0;
        ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
      end else begin
        dwell_d = dwell_q + DW_W'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q    <= '0;
      dwell_q <= '0;
    end else begin
      ch_q    <= ch_d;
      dwell_q <= dwell_d;
    end
  end

  assign ch = ch_q;

endmodule

// File: rtl/mux_scan_nx1.sv
// N-channel W-bit registered multiplexer with manual select and timed auto-scan.
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter  int unsigned WIDTH  = 8,
  parameter  int unsigned NUM_CH = 4,
  parameter  int unsigned DWELL  = 4,
  localparam int unsigned SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  output logic                    sel_err
);

  // When NUM_CH fills the select space every sel value is legal.
  localparam bit SEL_FULL = (NUM_CH == (32'd1 << SEL_W));

  logic [ST_W-1:0]  state_q, state_d;
  logic [SEL_W-1:0] scan_ch;
  logic             cnt_run, cnt_clear;
  logic             sel_ok_c;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] ch_data [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_split
    assign ch_data[k] = in_data[k*WIDTH +: WIDTH];
  end

  scan_counter #(
    .NUM_CH (NUM_CH),
    .DWELL  (DWELL)
  ) u_scan_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (cnt_run),
    .clear (cnt_clear),
    .ch    (scan_ch)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      sel_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      sel_err_q   <= sel_err_d;
    end
  end

  // Next state follows en/mode directly so a mode change applies this cycle.
  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      state_d = (mode == MODE_SCAN) ? ST_SCAN : ST_MANUAL;
    end
  end

  // Output selection and scan-counter control for the state being entered.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;
    sel_err_d   = 1'b0;
    sel_ok_c    = SEL_FULL || (32'(sel) < 32'(NUM_CH));
    cnt_run     = 1'b0;
    // Entering manual discards any frozen scan position; idle keeps it.
    cnt_clear   = (state_d == ST_MANUAL) && (state_q != ST_MANUAL);
    case (state_d)
      ST_MANUAL: begin
        if (sel_ok_c) begin
          out_data_d  = ch_data[sel];
          out_ch_d    = sel;
          out_valid_d = 1'b1;
        end else begin
          sel_err_d   = 1'b1;
        end
      end
      ST_SCAN: begin
        out_data_d  = ch_data[scan_ch];
        out_ch_d    = scan_ch;
        out_valid_d = 1'b1;
        cnt_run     = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// Scoreboard bench: dut_a is 4 channels / dwell 3, dut_b is 5 channels / dwell 1.
module tb_mux_scan_nx1;

  typedef struct packed {
    logic       v;
    logic       err;
    logic [7:0] d;
    logic [2:0] ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] in_a;
  logic        en_a, mode_a;
  logic [1:0]  sel_a;
  logic [7:0]  od_a;
  logic [1:0]  oc_a;
  logic        ov_a, oe_a;

  logic [39:0] in_b;
  logic        en_b, mode_b;
  logic [2:0]  sel_b;
  logic [7:0]  od_b;
  logic [2:0]  oc_b;
  logic        ov_b, oe_b;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0;
  int   errors = 0;
  int   na = 0;
  int   nb = 0;

  localparam logic [31:0] IN_A = 32'h44332211;
  localparam logic [39:0] IN_B = 40'h5544332211;
  logic [7:0] bytes_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] bytes_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  mux_scan_nx1 #(.WIDTH(8), .NUM_CH(4), .DWELL(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(in_a), .en(en_a), .mode(mode_a), .sel(sel_a),
    .out_data(od_a), .out_ch(oc_a), .out_valid(ov_a), .sel_err(oe_a)
  );

  mux_scan_nx1 #(.WIDTH(8), .NUM_CH(5), .DWELL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(in_b), .en(en_b), .mode(mode_b), .sel(sel_b),
    .out_data(od_b), .out_ch(oc_b), .out_valid(ov_b), .sel_err(oe_b)
  );

  function automatic exp_t mk(input logic v, input logic err, input logic [7:0] d,
                              input logic [2:0] ch);
    exp_t e;
    e.v = v; e.err = err; e.d = d; e.ch = ch;
    return e;
  endfunction

  task automatic check(input string name, input exp_t act, input exp_t want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got v=%b err=%b d=%h ch=%0d, want v=%b err=%b d=%h ch=%0d",
               name, act.v, act.err, act.d, act.ch, want.v, want.err, want.d, want.ch);
    end
  endtask

  task automatic step_a(input logic en, input logic mode, input logic [1:0] sel,
                        input logic [31:0] din, input exp_t e);
    @(negedge clk);
    en_a = en; mode_a = mode; sel_a = sel; in_a = din;
    qa.push_back(e);
  endtask

  task automatic step_b(input logic en, input logic mode, input logic [2:0] sel,
                        input logic [39:0] din, input exp_t e);
    @(negedge clk);
    en_b = en; mode_b = mode; sel_b = sel; in_b = din;
    qb.push_back(e);
  endtask

  // Monitors: compare each registered output one edge after its stimulus.
  always begin
    @(posedge clk);
    #1;
    if (qa.size() != 0) begin
      ea = qa.pop_front();
      na++;
      check($sformatf("dut_a out #%0d", na), mk(ov_a, oe_a, od_a, {1'b0, oc_a}), ea);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (qb.size() != 0) begin
      eb = qb.pop_front();
      nb++;
      check($sformatf("dut_b out #%0d", nb), mk(ov_b, oe_b, od_b, oc_b), eb);
    end
  end

  initial begin
    rst_n = 1'b0;
    en_a = 1'b0; mode_a = 1'b0; sel_a = '0; in_a = IN_A;
    en_b = 1'b0; mode_b = 1'b0; sel_b = '0; in_b = IN_B;
    repeat (2) @(negedge clk);
    check("reset a", mk(ov_a, oe_a, od_a, {1'b0, oc_a}), mk(0, 0, 8'h00, 3'd0));
    check("reset b", mk(ov_b, oe_b, od_b, oc_b), mk(0, 0, 8'h00, 3'd0));
    rst_n = 1'b1;

    // Manual selects.
    step_a(1, 0, 2'd2, IN_A, mk(1, 0, 8'h33, 3'd2));
    step_a(1, 0, 2'd0, IN_A, mk(1, 0, 8'h11, 3'd0));
    step_a(1, 0, 2'd3, IN_A, mk(1, 0, 8'h44, 3'd3));

    // Scan with dwell 3 and wrap back to channel 0.
    for (int i = 0; i < 13; i++) begin
      step_a(1, 1, 2'd0, IN_A, mk(1, 0, bytes_a[(i / 3) % 4], 3'((i / 3) % 4)));
    end
    step_a(1, 1, 2'd0, IN_A, mk(1, 0, 8'h11, 3'd0));
    step_a(1, 1, 2'd0, IN_A, mk(1, 0, 8'h11, 3'd0));
    step_a(1, 1, 2'd0, IN_A, mk(1, 0, 8'h22, 3'd1));
    step_a(1, 1, 2'd0, IN_A, mk(1, 0, 8'h22, 3'd1));

    // Freeze mid-dwell, then resume without restarting.
    for (int i = 0; i < 5; i++) begin
      step_a(0, 1, 2'd0, IN_A, mk(0, 0, 8'h22, 3'd1));
    end
    step_a(1, 1, 2'd0, IN_A, mk(1, 0, 8'h22, 3'd1));
    step_a(1, 1, 2'd0, IN_A, mk(1, 0, 8'h33, 3'd2));

    // Scan -> manual -> scan restarts at channel 0.
    step_a(1, 0, 2'd3, IN_A, mk(1, 0, 8'h44, 3'd3));
    step_a(1, 1, 2'd3, IN_A, mk(1, 0, 8'h11, 3'd0));
    step_a(1, 1, 2'd3, IN_A, mk(1, 0, 8'h11, 3'd0));
    step_a(1, 1, 2'd3, IN_A, mk(1, 0, 8'h11, 3'd0));
    step_a(1, 1, 2'd3, IN_A, mk(1, 0, 8'h22, 3'd1));

    // Non-selected channel change is invisible; selected change propagates.
    step_a(1, 0, 2'd1, 32'h443322A5, mk(1, 0, 8'h22, 3'd1));
    step_a(1, 0, 2'd1, 32'h443377A5, mk(1, 0, 8'h77, 3'd1));
    step_a(0, 0, 2'd1, 32'h443377A5, mk(0, 0, 8'h77, 3'd1));
    step_a(1, 1, 2'd1, 32'h443377A5, mk(1, 0, 8'hA5, 3'd0));
    step_a(1, 1, 2'd1, 32'h443377A5, mk(1, 0, 8'hA5, 3'd0));

    // Asynchronous reset mid-scan clears outputs before the next edge.
    @(posedge clk);
    #2;
    en_a = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid-cycle reset a", mk(ov_a, oe_a, od_a, {1'b0, oc_a}), mk(0, 0, 8'h00, 3'd0));
    @(negedge clk);
    rst_n = 1'b1;
    step_a(1, 1, 2'd0, 32'h443377A5, mk(1, 0, 8'hA5, 3'd0));
    step_a(1, 1, 2'd0, 32'h443377A5, mk(1, 0, 8'hA5, 3'd0));
    step_a(1, 1, 2'd0, 32'h443377A5, mk(1, 0, 8'hA5, 3'd0));
    step_a(1, 1, 2'd0, 32'h443377A5, mk(1, 0, 8'h77, 3'd1));
    step_a(0, 0, 2'd0, 32'h443377A5, mk(0, 0, 8'h77, 3'd1));

    // Five channels: illegal selects hold data and flag sel_err.
    step_b(1, 0, 3'd1, IN_B, mk(1, 0, 8'h22, 3'd1));
    step_b(1, 0, 3'd6, IN_B, mk(0, 1, 8'h22, 3'd1));
    step_b(1, 0, 3'd4, IN_B, mk(1, 0, 8'h55, 3'd4));
    step_b(1, 0, 3'd5, IN_B, mk(0, 1, 8'h55, 3'd4));

    // Dwell 1 advances every cycle and wraps 4 -> 0.
    for (int i = 0; i < 6; i++) begin
      step_b(1, 1, 3'd7, IN_B, mk(1, 0, bytes_b[i % 5], 3'(i % 5)));
    end
    step_b(0, 0, 3'd7, IN_B, mk(0, 0, 8'h11, 3'd0));
    step_b(1, 1, 3'd6, IN_B, mk(1, 0, 8'h22, 3'd1));
    step_b(1, 1, 3'd6, IN_B, mk(1, 0, 8'h33, 3'd2));
    step_b(1, 0, 3'd6, IN_B, mk(0, 1, 8'h33, 3'd2));
    step_b(1, 1, 3'd6, IN_B, mk(1, 0, 8'h11, 3'd0));
    step_b(0, 0, 3'd0, IN_B, mk(0, 0, 8'h11, 3'd0));

    repeat (3) @(negedge clk);
    checks++;
    if (qa.size() + qb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: got %0d pending entries, want 0", qa.size() + qb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
